if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly upstream of decode control.
- Issues one-outstanding 64-bit reads to the AXI bridge on a valid/ready request channel, then extracts the 32-bit instruction selected by pc[2].
- Buffers {pc, inst} pairs in a small FIFO and hands them to the IF/ID register with a valid/ready handshake.
- Handles redirects from branch/jump/trap/mret: flushes the queue and discards any in-flight stale response.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  redirect fetch this cycle (branch taken, jump, trap, mret).
- redirect_pc  input  64  new pc; bits [1:0] ignored, treated as 0.
- if_req_valid  output  1  read request valid.
- if_req_ready  input  1  bridge accepts request.
- if_req_addr  output  64  {pc[63:3],3'b000}; held stable while if_req_valid=1 and not accepted.
- if_resp_valid  input  1  read data valid; one response per accepted request, at least 1 cycle after acceptance.
- if_resp_data  input  64  read data.
- id_valid  output  1  head entry valid toward decode.
- id_ready  input  1  decode consumes head.
- id_inst  output  32  head instruction.
- id_pc  output  64  head pc.

Behaviour:
- Reset: state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr pointers=0, kill=0. Outputs if_req_valid=0, if_req_addr=0, id_valid=0, id_inst=0, id_pc=0.
- FSM states: IDLE, REQ, RESP, DROP.
- IDLE, no redirect, count<DEPTH:
  - Next state REQ; latch req_pc=fetch_pc.
  - if_req_valid and if_req_addr are registered, so the first request is asserted 1 cycle after reset release.
- IDLE with a redirect: fetch_pc<=redirect_pc; stays IDLE that cycle.
- REQ:
  - if_req_valid=1 and the address is held until if_req_ready.
  - On handshake: next state is DROP if kill was set or redirect_valid is high this cycle; otherwise RESP. kill<=0.
  - Redirect in REQ before the handshake sets kill=1. The request still completes with its old address, so AXI stability is never violated.
- RESP: on if_resp_valid, push {req_pc, req_pc[2] ? data[63:32] : data[31:0]}; fetch_pc<=req_pc+4; next state IDLE.
- DROP: on if_resp_valid, discard the data; next state IDLE. fetch_pc already holds the redirect target.
- Redirect rules (all states, highest priority over push):
  - count<=0; pointers reset; fetch_pc<=redirect_pc.
  - In RESP without if_resp_valid: next state DROP.
  - In RESP with if_resp_valid the same cycle: the response is discarded and the next state is IDLE.
  - Redirect in DROP: stays DROP, fetch_pc updated.
- Slot reservation:
  - A request is launched only when count<DEPTH.
  - The queue only grows via the single outstanding response, so a push never overflows.
  - A push to a full queue is an assertion failure in simulation.
- Decode side:
  - id_valid = (count!=0) & ~redirect_valid.
  - id_inst/id_pc come from the head entry, combinationally off registered storage.
  - Pop occurs on id_valid & id_ready.
  - Simultaneous push and pop: count unchanged, pointers both advance.
- Pointer arithmetic: modulo DEPTH wrap; count width clog2(DEPTH)+1; fetch_pc+4 wraps mod 2^64.
- Latency:
  - Response arriving in cycle t gives id_valid in cycle t+1.
  - Steady-state throughput, with a 1-cycle ready and 1-cycle response bridge, is one instruction per 3 cycles (IDLE, REQ, RESP).
- rst asserted mid-transaction: FSM returns to IDLE and all state clears. The bridge is reset by the same rst, so no stale response is expected.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (64) and perf_dropped (64), both reset to 0.
  - perf_fetched increments on each push.
  - perf_dropped increments on each discarded response: DROP, or RESP with a same-cycle redirect.
  - Both counters saturate at all-ones.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, ready=1, response 1 cycle after accept with data 64'h0000_0013_0000_0093 → first if_req_addr=0x8000_0000; id_valid with id_pc=0x8000_0000, id_inst=0x0000_0093; next entry id_pc=0x8000_0004, id_inst=0x0000_0013 (same 8-byte line, second read).
- id_ready=0 held, DEPTH=4 → exactly 4 entries pushed, if_req_valid stays 0 afterward; one pop → exactly one new request issued.
- Redirect to 0x8000_0100 while in RESP, response arriving 3 cycles later → response discarded, queue empty, next if_req_addr=0x8000_0100, perf_dropped=1.
- if_req_ready=0 for 5 cycles, redirect to 0x8000_0204 in cycle 2 → if_req_addr stays at the old address until accepted; its response is dropped; next request addr=0x8000_0200, pushed inst taken from data[63:32], id_pc=0x8000_0204.
- Redirect in the same cycle as if_resp_valid in RESP, with 2 entries queued → count=0, id_valid=0 that cycle, no push; next request at the redirect pc.
- Full queue with simultaneous pop and push → count stays 4, head advances, no overflow assertion fired.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch stage, one outstanding 64-bit read, {pc,inst} queue toward decode; IF_FETCH_PERF_EN adds perf counters.
// Latency: request 1 cycle after entering IDLE with room; response in cycle t -> id_valid in t+1.
// Backpressure: no read is launched while the queue is full; id_ready stalls the head; if_req_addr held until accepted.
module if_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        if_req_valid,
   input  logic        if_req_ready,
   output logic [63:0] if_req_addr,
   input  logic        if_resp_valid,
   input  logic [63:0] if_resp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [63:0] id_pc
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [63:0] perf_fetched,
   output logic [63:0] perf_dropped
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DROP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [63:0]     fetch_pc;
   logic [63:0]     req_pc;
   logic            kill;
   logic [CW-1:0]   count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [63:0]     pc_mem   [DEPTH];
   logic [31:0]     inst_mem [DEPTH];

   logic            req_fire;
   logic            launch;
   logic            push;
   logic            pop;
   logic            discard;
   logic [63:0]     redir_pc_al;
   logic [31:0]     resp_inst;
   logic            unused_ok;

   assign req_fire    = if_req_valid & if_req_ready;
   assign redir_pc_al = {redirect_pc[63:2], 2'b00};
   assign unused_ok   = &redirect_pc[1:0];
   assign resp_inst   = req_pc[2] ? if_resp_data[63:32] : if_resp_data[31:0];
   assign id_valid    = (count != '0) & ~redirect_valid;
   assign id_inst     = inst_mem[rd_ptr];
   assign id_pc       = pc_mem[rd_ptr];
   assign pop         = id_valid & id_ready;

   // Next-state and per-cycle strobes; a redirect always beats a push.
   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      push      = 1'b0;
      discard   = 1'b0;
      case (state)
         IDLE: begin
            if (!redirect_valid && (count < FULL)) begin
               state_nxt = REQ;
               launch    = 1'b1;
            end
         end
         REQ: begin
            if (req_fire) state_nxt = (kill | redirect_valid) ? DROP : RESP;
         end
         RESP: begin
            if (if_resp_valid) begin
               state_nxt = IDLE;
               if (redirect_valid) discard = 1'b1;
               else                push    = 1'b1;
            end else if (redirect_valid) begin
               state_nxt = DROP;
            end
         end
         DROP: begin
            if (if_resp_valid) begin
               state_nxt = IDLE;
               discard   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Fetch pc, request channel registers and the stale-request kill flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc     <= RESET_PC;
         req_pc       <= '0;
         kill         <= 1'b0;
         if_req_valid <= 1'b0;
         if_req_addr  <= '0;
      end else begin
         if (launch) begin
            req_pc       <= fetch_pc;
            if_req_valid <= 1'b1;
            if_req_addr  <= {fetch_pc[63:3], 3'b000};
         end else if (req_fire) begin
            if_req_valid <= 1'b0;
         end
         // The address must stay put on a redirect, so remember to drop its data instead.
         if (state == REQ) begin
            if (req_fire)            kill <= 1'b0;
            else if (redirect_valid) kill <= 1'b1;
         end
         if (redirect_valid) fetch_pc <= redir_pc_al;
         else if (push)      fetch_pc <= req_pc + 64'd4;
      end
   end

   // Queue storage and occupancy; a redirect flushes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else if (redirect_valid) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            pc_mem[wr_ptr]   <= req_pc;
            inst_mem[wr_ptr] <= resp_inst;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
      end
   end

   // A slot is reserved before every launch, so a push can never see a full queue.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && (count == FULL)))
            else $error("if_fetch_queue: push into full queue");
      end
   end

`ifdef IF_FETCH_PERF_EN
   // Saturating counters of delivered and discarded responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         if (push && (perf_fetched != '1))    perf_fetched <= perf_fetched + 64'd1;
         if (discard && (perf_dropped != '1)) perf_dropped <= perf_dropped + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: bridge model plus {pc,inst} scoreboard around if_fetch_queue.
// Directed scenarios for reset, fill, redirects in each state, then a random phase and a mid-run reset.
// Scoreboard is refilled with the expected sequential stream whenever a redirect or reset release is driven.
module tb_if_fetch_queue;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] KEY    = 32'h1357_9BDF;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [63:0] if_req_addr;
   logic        if_resp_valid;
   logic [63:0] if_resp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [63:0] id_pc;
`ifdef IF_FETCH_PERF_EN
   logic [63:0] perf_fetched;
   logic [63:0] perf_dropped;
`endif

   if_fetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
`ifdef IF_FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Program image: the reset line holds two known opcodes, everything else is pc ^ KEY.
   function automatic logic [31:0] inst_at(input logic [63:0] pc);
      logic [60:0] rst_line;
      rst_line = 61'(RST_PC >> 3);
      if (pc[63:3] == rst_line) return pc[2] ? 32'h0000_0013 : 32'h0000_0093;
      return pc[31:0] ^ KEY;
   endfunction

   function automatic logic [63:0] mem_line(input logic [63:0] a);
      logic [63:0] b;
      b = {a[63:3], 3'b000};
      return {inst_at(b + 64'd4), inst_at(b)};
   endfunction

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t exp_q[$];

   task automatic sb_refill(input logic [63:0] pc0);
      logic [63:0] p;
      ent_t        e;
      p = {pc0[63:2], 2'b00};
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         e.pc   = p;
         e.inst = inst_at(p);
         exp_q.push_back(e);
         p = p + 64'd4;
      end
   endtask

   // Monitor: request stability, accepted addresses and scoreboard compare on each handoff.
   int          acc_cnt = 0;
   logic [63:0] last_acc_addr = '0;
   logic [63:0] acc_addr_q[$];
   bit          prev_stall = 1'b0;
   logic [63:0] prev_addr = '0;

   always @(negedge clk) begin
      ent_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("req_hold_vld", if_req_valid, 1);
            check("req_hold_addr", if_req_addr, prev_addr);
         end
         prev_stall = if_req_valid & ~if_req_ready;
         prev_addr  = if_req_addr;
         if (if_req_valid && if_req_ready) begin
            acc_cnt++;
            last_acc_addr = if_req_addr;
            acc_addr_q.push_back(if_req_addr);
         end
         if (id_valid && id_ready) begin
            check("sb_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_pc", id_pc, e.pc);
               check("sb_inst", id_inst, e.inst);
            end
         end
      end
   end

   // Bridge: one response per accepted request, resp_delay (>=1) cycles after acceptance.
   int          resp_delay = 1;
   bit          rnd_delay  = 1'b0;
   bit          pend       = 1'b0;
   int          pend_cnt   = 0;
   logic [63:0] pend_addr  = '0;

   initial begin
      if_resp_valid = 1'b0;
      if_resp_data  = '0;
      forever begin
         @(posedge clk); #1;
         if_resp_valid = 1'b0;
         if (rst) begin
            pend = 1'b0;
            acc_addr_q.delete();
         end else begin
            if (acc_addr_q.size() != 0) begin
               pend      = 1'b1;
               pend_addr = acc_addr_q.pop_front();
               pend_cnt  = rnd_delay ? $urandom_range(1, 3) : resp_delay;
            end
            if (pend) begin
               if (pend_cnt <= 1) begin
                  if_resp_valid = 1'b1;
                  if_resp_data  = mem_line(pend_addr);
                  pend          = 1'b0;
               end else begin
                  pend_cnt--;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_acc(input string tag);
      int n0;
      n0 = acc_cnt;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (acc_cnt != n0) break;
      end
      check({tag, "_tmo"}, acc_cnt != n0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      logic [63:0] hold_addr;
      logic [63:0] rp;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      if_req_ready = 1'b1; id_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_vld", if_req_valid, 0);
      check("rst_req_addr", if_req_addr, 0);
      check("rst_id_vld", id_valid, 0);
      check("rst_id_inst", id_inst, 0);
      check("rst_id_pc", id_pc, 0);
      tick();
      rst = 1'b0;
      sb_refill(RST_PC);
      base = acc_cnt;

      // First fetch: request one cycle after release, data visible the cycle after the response.
      @(negedge clk); check("first_idle_vld", if_req_valid, 0);
      @(negedge clk); check("first_req_vld", if_req_valid, 1);
      check("first_req_addr", if_req_addr, 64'h0000_0000_8000_0000);
      @(negedge clk); check("resp_cycle_id_vld", id_valid, 0);
      @(negedge clk); check("lat_id_vld", id_valid, 1);
      check("lat_id_pc", id_pc, 64'h0000_0000_8000_0000);
      check("lat_id_inst", id_inst, 64'h0000_0093);
      tick();

      // Fill with decode stalled: exactly DEPTH fetches, then silence.
      repeat (30) tick();
      check("fill_acc", acc_cnt - base, 4);
      check("fill_req_vld", if_req_valid, 0);
      check("fill_id_vld", id_valid, 1);
`ifdef IF_FETCH_PERF_EN
      check("perf_fetched_fill", perf_fetched, 4);
`endif
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      check("head2_pc", id_pc, 64'h0000_0000_8000_0004);
      check("head2_inst", id_inst, 64'h0000_0013);
      base = acc_cnt;
      repeat (30) tick();
      check("refill_acc", acc_cnt - base, 1);
      check("refill_req_vld", if_req_valid, 0);

      // Pop and push in the same cycle.
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      wait_acc("pp_acc");
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      check("pp_head_pc", id_pc, 64'h0000_0000_8000_000C);
      base = acc_cnt;
      repeat (30) tick();
      check("pp_acc_after", acc_cnt - base, 1);
      check("pp_id_vld", id_valid, 1);

      // Redirect while waiting in RESP; the late response must be dropped.
      id_ready = 1'b1; resp_delay = 3;
      wait_acc("t3_acc");
      redirect_pc = 64'h0000_0000_8000_0100; redirect_valid = 1'b1;
      sb_refill(redirect_pc);
      @(negedge clk); check("t3_id_vld0", id_valid, 0);
      tick(); redirect_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk); check("t3_id_vld", id_valid, 0);
      end
      tick();
      wait_acc("t3_next");
      check("t3_next_addr", last_acc_addr, 64'h0000_0000_8000_0100);
      resp_delay = 1;
`ifdef IF_FETCH_PERF_EN
      check("t3_perf_dropped", perf_dropped, 1);
`endif

      // Redirect while a request is stalled: address held, data dropped, refetch from the new line.
      if_req_ready = 1'b0;
      for (int i = 0; i < 40 && !if_req_valid; i++) tick();
      check("t4_req_seen", if_req_valid, 1);
      hold_addr = if_req_addr;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            redirect_pc = 64'h0000_0000_8000_0204; redirect_valid = 1'b1;
            sb_refill(redirect_pc);
         end
         if (k == 3) redirect_valid = 1'b0;
         if (k > 0) begin
            check("t4_stall_vld", if_req_valid, 1);
            check("t4_stall_addr", if_req_addr, hold_addr);
         end
         tick();
      end
      if_req_ready = 1'b1;
      wait_acc("t4_old");
      check("t4_old_addr", last_acc_addr, hold_addr);
      wait_acc("t4_new");
      check("t4_new_addr", last_acc_addr, 64'h0000_0000_8000_0200);
      for (int i = 0; i < 20 && !id_valid; i++) tick();
      check("t4_id_pc", id_pc, 64'h0000_0000_8000_0204);
      check("t4_id_inst", id_inst, 64'h8000_0204 ^ 64'(KEY));

      // Redirect in the same cycle as the response, with two entries queued.
      tick(); id_ready = 1'b0;
      repeat (30) tick();
      redirect_pc = 64'h0000_0000_8000_0300; redirect_valid = 1'b1;
      sb_refill(redirect_pc);
      tick(); redirect_valid = 1'b0;
      wait_acc("t5_a"); check("t5_a_addr", last_acc_addr, 64'h0000_0000_8000_0300);
      wait_acc("t5_b"); check("t5_b_addr", last_acc_addr, 64'h0000_0000_8000_0300);
      wait_acc("t5_c"); check("t5_c_addr", last_acc_addr, 64'h0000_0000_8000_0308);
      check("t5_pre_vld", id_valid, 1);
      check("t5_resp_now", if_resp_valid, 1);
      redirect_pc = 64'h0000_0000_8000_0400; redirect_valid = 1'b1;
      sb_refill(redirect_pc);
      @(negedge clk); check("t5_redir_vld", id_valid, 0);
      tick(); redirect_valid = 1'b0;
      @(negedge clk); check("t5_post_vld", id_valid, 0);
      tick();
      wait_acc("t5_next"); check("t5_next_addr", last_acc_addr, 64'h0000_0000_8000_0400);
`ifdef IF_FETCH_PERF_EN
      check("t5_perf_dropped", perf_dropped, 3);
`endif

      // Random traffic with occasional redirects (low pc bits randomised).
      rnd_delay = 1'b1;
      for (int i = 0; i < 600; i++) begin
         id_ready     = ($urandom_range(0, 3) != 0);
         if_req_ready = ($urandom_range(0, 2) != 0);
         if (redirect_valid) begin
            redirect_valid = 1'b0;
         end else if ($urandom_range(0, 24) == 0) begin
            rp = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
            redirect_pc = rp; redirect_valid = 1'b1;
            sb_refill(rp);
         end
         tick();
      end
      redirect_valid = 1'b0;
      tick();

      // Wrap of the fetch pc past 2^64.
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE; redirect_valid = 1'b1;
      sb_refill(redirect_pc);
      tick(); redirect_valid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         id_ready     = ($urandom_range(0, 3) != 0);
         if_req_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      if_req_ready = 1'b1;

      // Reset in the middle of traffic.
      id_ready = 1'b1;
      repeat (7) tick();
      rst = 1'b1;
      tick(); tick();
      @(negedge clk);
      check("mid_rst_req_vld", if_req_valid, 0);
      check("mid_rst_req_addr", if_req_addr, 0);
      check("mid_rst_id_vld", id_valid, 0);
      check("mid_rst_id_pc", id_pc, 0);
      tick();
      rst = 1'b0;
      sb_refill(RST_PC);
      wait_acc("mid_rst_acc");
      check("mid_rst_addr", last_acc_addr, 64'h0000_0000_8000_0000);
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
